// File: rtl/flash_rd_cache_pkg.sv
// Shared state encoding and default address width for the flash read cache.
package flash_rd_cache_pkg;

    localparam int AW_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ACK  = 3'd2,
        ST_HOLD = 3'd3,
        ST_PREF = 3'd4
    } state_t;

endpackage

// File: rtl/flash_rd_cache_store.sv
// Valid/tag/data arrays of the flash read cache: one write port, combinational read,
// synchronous clear of every valid bit.
module flash_rd_cache_store
    import flash_rd_cache_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IW      = $clog2(ENTRIES),
    parameter int TW      = AW_DEFAULT - IW - 2
) (
    input  logic          clk,
    input  logic          clear_all,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_valid,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_data
);

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    // A clear on the same edge as a write leaves that entry invalid.
    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/flash_rd_cache.sv
// Direct-mapped read-only word cache in front of the SPI flash controller.
// Define FLASH_CACHE_PREFETCH_EN to add the background next-word prefetch.
//
// state | meaning
// IDLE  | waiting for a CPU read; lookup happens on the request edge
// FILL  | miss outstanding at the flash controller
// ACK   | one-cycle acknowledge to the CPU
// HOLD  | requester drops cyc; CPU request ignored
// PREF  | background fill of the word after the last miss (prefetch build only)
module flash_rd_cache
    import flash_rd_cache_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int AW      = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cpu_valid,
    input  logic [AW-1:0] i_cpu_adr,
    output logic          o_cpu_ack,
    output logic [31:0]   o_cpu_rdt,
    input  logic          i_flush,
    output logic          o_mem_valid,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ready,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_hit
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = AW - IW - 2;

    state_t        state_q, state_nx;
    logic [AW-3:0] fetch_q, fetch_nx;
    logic [31:0]   rdt_q, rdt_nx;
    logic          flushed_q, flushed_nx;
    logic          hit_q, hit_nx;
    logic          ack_q, mem_valid_q;

    logic [AW-3:0] cpu_word, look_word;
    logic          look_hit;
    logic          wr_en, wr_valid;
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          unused_adr_lsb;

    assign cpu_word       = i_cpu_adr[AW-1:2];
    assign unused_adr_lsb = ^i_cpu_adr[1:0];

`ifdef FLASH_CACHE_PREFETCH_EN
    logic [AW-3:0] next_word;
    logic          miss_q, miss_nx;

    // fetch_q still holds the miss word while in HOLD; the +1 wraps at the top of flash.
    assign next_word = fetch_q + 1'b1;
    assign look_word = (state_q == ST_HOLD) ? next_word : cpu_word;
`else
    assign look_word = cpu_word;
`endif

    assign rd_idx   = look_word[IW-1:0];
    assign look_hit = rd_valid && (rd_tag == look_word[AW-3:IW]);

    flash_rd_cache_store #(
        .ENTRIES (ENTRIES),
        .IW      (IW),
        .TW      (TW)
    ) u_store (
        .clk       (clk),
        .clear_all (!rst_n || i_flush),
        .wr_en     (wr_en),
        .wr_idx    (fetch_q[IW-1:0]),
        .wr_valid  (wr_valid),
        .wr_tag    (fetch_q[AW-3:IW]),
        .wr_data   (i_mem_rdata),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

    always_comb begin
        state_nx   = state_q;
        fetch_nx   = fetch_q;
        rdt_nx     = rdt_q;
        hit_nx     = 1'b0;
        flushed_nx = flushed_q | i_flush;
        wr_en      = 1'b0;
        wr_valid   = 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
        miss_nx    = miss_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cpu_valid) begin
                    // A flush on the lookup edge wins over a hit.
                    if (look_hit && !i_flush) begin
                        rdt_nx   = rd_data;
                        hit_nx   = 1'b1;
                        state_nx = ST_ACK;
`ifdef FLASH_CACHE_PREFETCH_EN
                        miss_nx  = 1'b0;
`endif
                    end else begin
                        fetch_nx   = cpu_word;
                        flushed_nx = 1'b0;
                        state_nx   = ST_FILL;
`ifdef FLASH_CACHE_PREFETCH_EN
                        miss_nx    = 1'b1;
`endif
                    end
                end
            end
            ST_FILL: begin
                if (i_mem_ready) begin
                    wr_en    = 1'b1;
                    wr_valid = !(flushed_q || i_flush);
                    rdt_nx   = i_mem_rdata;
                    state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
`ifdef FLASH_CACHE_PREFETCH_EN
                if (miss_q && !(look_hit && !i_flush)) begin
                    fetch_nx   = next_word;
                    flushed_nx = 1'b0;
                    state_nx   = ST_PREF;
                end else begin
                    state_nx = ST_IDLE;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
`ifdef FLASH_CACHE_PREFETCH_EN
            ST_PREF: begin
                if (i_mem_ready) begin
                    wr_en    = 1'b1;
                    wr_valid = !(flushed_q || i_flush);
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_q     <= '0;
            rdt_q       <= '0;
            flushed_q   <= 1'b0;
            hit_q       <= 1'b0;
            ack_q       <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            fetch_q     <= fetch_nx;
            rdt_q       <= rdt_nx;
            flushed_q   <= flushed_nx;
            hit_q       <= hit_nx;
            ack_q       <= (state_nx == ST_ACK);
            mem_valid_q <= (state_nx == ST_FILL) || (state_nx == ST_PREF);
        end
    end

`ifdef FLASH_CACHE_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_q <= 1'b0;
        end else begin
            miss_q <= miss_nx;
        end
    end
`endif

    assign o_cpu_ack   = ack_q;
    assign o_cpu_rdt   = rdt_q;
    assign o_hit       = hit_q;
    assign o_mem_valid = mem_valid_q;
    assign o_mem_addr  = {fetch_q, 2'b00};

endmodule

// File: doc/flash_rd_cache.md
# flash_rd_cache

Direct-mapped, read-only word cache between the SERV instruction/data-read path and the `spimemio` SPI flash controller. It serves repeated fetches (loops, constants) without a full SPI transaction and forwards misses to flash with a one-word fill. It has an optional sequential-prefetch engine that fills the next word in the background.

## Interface

Parameters:
- `ENTRIES`, default 8: number of cache words; must be a power of two, minimum 2. `IW = log2(ENTRIES)`.
- `AW`, default 24: flash byte-address width.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `i_cpu_valid`, in, 1: read request; asserted when ibus cyc is high, or dbus cyc is high with we low.
- `i_cpu_adr`, in, AW: byte address; bits [1:0] are ignored.
- `o_cpu_ack`, out, 1: single-cycle acknowledge.
- `o_cpu_rdt`, out, 32: read data; valid while `o_cpu_ack` is high.
- `i_flush`, in, 1: invalidates all entries.
- `o_mem_valid`, out, 1: request to `spimemio`.
- `o_mem_addr`, out, AW: word-aligned address; bits [1:0] are always 0.
- `i_mem_ready`, in, 1: `spimemio` data-valid strobe.
- `i_mem_rdata`, in, 32: `spimemio` read data.
- `o_hit`, out, 1: one-cycle pulse per CPU request served from the cache.

## Operation

- Index = `adr[IW+1:2]`; tag = `adr[AW-1:IW+2]`. Each entry holds a valid bit, the tag, and 32 bits of data.
- States: IDLE, FILL, ACK, HOLD, plus PREF when the prefetch macro is defined.
- IDLE: on `i_cpu_valid`, latch the address.
  - Hit: latch the entry data, pulse `o_hit`, go to ACK.
  - Miss: go to FILL.
- FILL:
  - `o_mem_valid`=1 and `o_mem_addr`={latched[AW-1:2],2'b00}, both held stable until `i_mem_ready`.
  - On `i_mem_ready`: write the entry (valid=1, tag, data), latch `i_mem_rdata` into `o_cpu_rdt`, go to ACK.
- ACK: `o_cpu_ack`=1 for exactly one cycle, then go to HOLD.
- HOLD: one cycle in which `i_cpu_valid` is ignored, because the requester drops cyc in this cycle. Then go to IDLE, or to PREF (see Configuration).
- Flush:
  - `i_flush` sampled high clears all valid bits at that edge.
  - If the flush coincides with an IDLE lookup, the flush wins and the request is treated as a miss.
  - If the flush arrives during FILL, the fill completes and the data is returned to the CPU, but the entry is written with valid=0.
- Reset mid-FILL: all state returns to reset values at the edge. `spimemio` shares `rst_n`, so no transaction is left dangling.
- `o_cpu_rdt` holds its last value outside ACK.

## Timing

- Reset values: `o_cpu_ack`=0, `o_cpu_rdt`=0, `o_mem_valid`=0, `o_mem_addr`=0, `o_hit`=0, state=IDLE, all valid bits 0.
- Hit: request sampled at edge N → `o_hit` high in cycle N+1 and `o_cpu_ack` high in cycle N+1. Back-to-back hit requests are spaced 3 cycles apart.
- Miss: request sampled at edge N → `o_mem_valid` high from cycle N+1. If `i_mem_ready` is sampled at edge M, `o_cpu_ack` is high in cycle M+1.
- `o_mem_valid` drops in the cycle after `i_mem_ready` and never toggles while waiting.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Configuration

- `FLASH_CACHE_PREFETCH_EN` defined:
  - On leaving HOLD after a miss, compute next = latched + 4, wrapping modulo 2^AW (0xFFFFFC → 0x000000).
  - If the entry for next is not valid with next's tag, enter PREF: issue `o_mem_valid` for next, write the entry on `i_mem_ready`, then return to IDLE.
  - Any CPU request arriving during PREF waits until PREF completes, then is looked up normally. A transaction in flight to `spimemio` cannot be aborted.
  - A flush during PREF makes the written entry invalid.
- `FLASH_CACHE_PREFETCH_EN` undefined: the PREF state and the next-address logic are absent, and HOLD always goes to IDLE.

## Structure

- Package `flash_rd_cache_pkg`: state encoding constants (IDLE/FILL/ACK/HOLD/PREF) and the default `AW`.
- Sub-module `flash_rd_cache_store`: the valid/tag/data arrays.
  - Single write port.
  - Combinational read by index.
  - Synchronous `clear_all` input for flush and reset.
- The controller FSM lives in `flash_rd_cache`.

## Test plan

- Cold miss: read 0x000100 with the flash model returning 0xDEADBEEF after 70 cycles → one `o_mem_valid` burst with addr 0x000100; `o_cpu_ack` 1 cycle after ready; rdt=0xDEADBEEF; `o_hit`=0.
- Hit: repeat the read of 0x000100 → ack 1 cycle after the request; `o_hit`=1; no `o_mem_valid`.
- Conflict: with ENTRIES=8, read 0x000100, then 0x000120 (same index, different tag), then 0x000100 → three misses, three flash transactions.
- Flush: cache 0x000040, then pulse `i_flush` → the next read of 0x000040 misses. Also assert flush during a FILL → data is returned, and an immediate re-read misses.
- Prefetch (macro on): miss at 0xFFFFFC → after ack, `o_mem_valid` with addr 0x000000; a subsequent read of 0x000000 hits. With the macro off, the same read misses.
- Reset: drop `rst_n` mid-FILL → `o_mem_valid`=0 and `o_cpu_ack`=0 at the next edge; a read after reset misses.
